program_loader: RTL and testbench

Loader that writes a program image into the instruction/data memory at run time, so programs no longer have to be baked into `initial` blocks. It accepts a stream of 32-bit instruction words over a valid/ready handshake and issues one memory write per word, at consecutive addresses from a programmable base. It holds the processor in halt while loading and reports completion, range error and a running checksum. It sits between the external input source (host/disk interface) and the memory's `dado`/`endereco`/`write` port.

---
 rtl/loader_pkg.sv | 19 +
 rtl/program_loader.sv | 100 ++++++++++
 tb/tb_program_loader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and defaults for the run-time program loader.
// Also carries the HLT opcode used to terminate test images.
package loader_pkg;

    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = 32;
    localparam int MAX_WORDS  = 512;

    localparam logic [5:0] HLT = 6'b010010;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_e;

endpackage

// File: rtl/program_loader.sv
// Streams 32-bit words into instruction memory from a base address,
// holding the CPU halted and tracking a running checksum.
module program_loader #(
    parameter int ADDR_WIDTH = loader_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = loader_pkg::DATA_WIDTH,
    parameter int MAX_WORDS  = loader_pkg::MAX_WORDS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_count,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] mem_dado,
    output logic [ADDR_WIDTH-1:0] mem_endereco,
    output logic                  mem_write,
    output logic                  cpu_halt,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] checksum
);

    import loader_pkg::*;

    localparam logic [ADDR_WIDTH:0] MAX_LIM = (ADDR_WIDTH+1)'(MAX_WORDS);

    state_e                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] remaining;
    logic [ADDR_WIDTH:0]   end_addr;
    logic                  range_bad;
    logic                  can_start;

    // Extra bit keeps the end address from wrapping.
    assign end_addr  = {1'b0, base_addr} + {1'b0, word_count};
    assign range_bad = end_addr > MAX_LIM;

    assign can_start = (state == S_IDLE)
                     | (state == S_DONE)
                     | (state == S_ERROR);

    assign in_ready  = (state == S_LOAD);
    assign mem_write = (state == S_WRITE);
    assign busy      = (state == S_LOAD) | (state == S_WRITE);
    assign cpu_halt  = busy;
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERROR);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= S_IDLE;
            addr         <= '0;
            remaining    <= '0;
            mem_dado     <= '0;
            mem_endereco <= '0;
            checksum     <= '0;
        end else begin
            unique case (1'b1)
                can_start: begin
                    if (start) begin
                        checksum <= '0;
                        if (range_bad) begin
                            state <= S_ERROR;
                        end else if (word_count == '0) begin
                            state <= S_DONE;
                        end else begin
                            addr      <= base_addr;
                            remaining <= word_count;
                            state     <= S_LOAD;
                        end
                    end
                end
                (state == S_LOAD): begin
                    if (in_valid) begin
                        mem_dado     <= in_data;
                        mem_endereco <= addr;
                        state        <= S_WRITE;
                    end
                end
                (state == S_WRITE): begin
                    checksum  <= checksum + mem_dado;
                    addr      <= addr + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == ADDR_WIDTH'(1)) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_LOAD;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader.
// Expected writes are queued by the driver and popped by the monitor.
module tb_program_loader;

    import loader_pkg::*;

    logic        clock;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [9:0]  word_count;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] mem_dado;
    logic [9:0]  mem_endereco;
    logic        mem_write;
    logic        cpu_halt;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    program_loader dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .word_count   (word_count),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_dado     (mem_dado),
        .mem_endereco (mem_endereco),
        .mem_write    (mem_write),
        .cpu_halt     (cpu_halt),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .checksum     (checksum)
    );

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          wr_cyc[$];
    logic [31:0] words[$];
    int          total  = 0;
    int          passed = 0;
    int          cyc    = 0;
    bit          prev_wr = 0;

    initial clock = 0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endfunction

    // Monitor: every presented write must match the head of the queue.
    always @(negedge clock) begin
        if (mem_write) begin
            wr_cyc.push_back(cyc);
            chk("no_back_to_back_write", {31'd0, prev_wr}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h expected none",
                         mem_endereco, mem_dado);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", {22'd0, mem_endereco}, {22'd0, e.a});
                chk("write_data", mem_dado, e.d);
            end
        end
        prev_wr = mem_write;
    end

    task automatic pulse_start(input int b, input int c);
        @(negedge clock);
        start      = 1;
        base_addr  = 10'(b);
        word_count = 10'(c);
        @(negedge clock);
        start = 0;
    endtask

    task automatic feed(input int cnt, input int vprob, input bit glitch);
        int idx   = 0;
        int guard = 0;
        bit gl    = 0;
        while (idx < cnt && guard < 4000) begin
            start    = 0;
            in_data  = words[idx];
            in_valid = ($urandom_range(0, 99) < vprob);
            if (glitch && !gl && idx == 1 && in_ready) begin
                start      = 1;
                base_addr  = 10'd0;
                word_count = 10'd1;
                gl         = 1;
            end
            if (in_valid && in_ready) idx++;
            @(negedge clock);
            guard++;
        end
        in_valid = 0;
        start    = 0;
        if (guard >= 4000) begin
            total++;
            $display("FAIL feed_timeout: got %0d words expected %0d", idx, cnt);
        end
    endtask

    task automatic run_load(input int b, input int c, input int vprob,
                            input bit glitch, input bit fixed);
        logic [31:0] sum = 0;
        int          g;
        if (!fixed) begin
            words.delete();
            for (int i = 0; i < c; i++) words.push_back($urandom);
        end
        wr_cyc.delete();
        if (b + c <= MAX_WORDS) begin
            for (int i = 0; i < c; i++) begin
                wr_t e;
                e.a = 10'(b + i);
                e.d = words[i];
                exp_q.push_back(e);
                sum += words[i];
            end
        end
        pulse_start(b, c);
        if (b + c > MAX_WORDS) begin
            chk("range_error", {31'd0, error}, 32'd1);
            chk("range_busy", {31'd0, busy}, 32'd0);
            repeat (4) @(negedge clock);
            chk("range_error_hold", {31'd0, error}, 32'd1);
        end else if (c == 0) begin
            chk("zero_done", {31'd0, done}, 32'd1);
            for (int i = 0; i < 3; i++) begin
                chk("zero_busy", {31'd0, busy}, 32'd0);
                @(negedge clock);
            end
        end else begin
            chk("load_busy", {31'd0, busy}, 32'd1);
            chk("load_halt", {31'd0, cpu_halt}, 32'd1);
            feed(c, vprob, glitch);
            g = 0;
            while (!done && g < 10) begin
                @(negedge clock);
                g++;
            end
            chk("load_done", {31'd0, done}, 32'd1);
            chk("load_done_busy", {31'd0, busy}, 32'd0);
            chk("load_done_halt", {31'd0, cpu_halt}, 32'd0);
            chk("load_checksum", checksum, sum);
            chk("load_queue_empty", exp_q.size(), 32'd0);
            chk("load_write_count", wr_cyc.size(), c);
            if (vprob == 100) begin
                for (int i = 1; i < wr_cyc.size(); i++)
                    chk("write_spacing", wr_cyc[i] - wr_cyc[i-1], 32'd2);
            end
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_cpu_halt", {31'd0, cpu_halt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_mem_dado", mem_dado, 32'd0);
        chk("rst_mem_endereco", {22'd0, mem_endereco}, 32'd0);
        chk("rst_checksum", checksum, 32'd0);
    endtask

    task automatic reset_mid_load();
        int seen  = 0;
        int guard = 0;
        int idx   = 0;
        words.delete();
        for (int i = 0; i < 5; i++) begin
            wr_t e;
            words.push_back($urandom);
            e.a = 10'(100 + i);
            e.d = words[i];
            exp_q.push_back(e);
        end
        pulse_start(100, 5);
        while (seen < 2 && guard < 200) begin
            in_data  = words[idx];
            in_valid = 1;
            if (in_ready) idx++;
            @(negedge clock);
            #1;
            guard++;
            if (mem_write) seen++;
        end
        chk("reset_test_writes_seen", seen, 32'd2);
        reset    = 0;
        in_valid = 0;
        exp_q.delete();
        @(negedge clock);
        check_reset_vals();
        reset = 1;
        repeat (6) @(negedge clock);
        chk("post_reset_idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset      = 0;
        start      = 0;
        base_addr  = 0;
        word_count = 0;
        in_valid   = 0;
        in_data    = 0;
        repeat (3) @(negedge clock);
        check_reset_vals();
        reset = 1;

        words.delete();
        words.push_back(32'h04000001);
        words.push_back(32'h54000029);
        words.push_back({HLT, 26'd0});
        run_load(34, 3, 100, 0, 1);

        run_load(510, 3, 100, 0, 0);
        run_load(509, 3, 100, 0, 0);
        run_load(0, 600, 100, 0, 0);
        run_load(7, 0, 100, 0, 0);

        for (int t = 0; t < 6; t++)
            run_load($urandom_range(0, 490), $urandom_range(1, 20),
                     $urandom_range(20, 80), 0, 0);

        run_load(200, 6, 60, 1, 0);

        reset_mid_load();
        run_load(300, 4, 100, 0, 0);

        for (int t = 0; t < 4; t++)
            run_load($urandom_range(0, 511), $urandom_range(0, 30),
                     $urandom_range(30, 100), 0, 0);

        repeat (3) @(negedge clock);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
